// File: rtl/exec_sequencer.sv
// Execute-strobe sequencer: issues a one-cycle Go per instruction in free-run
// (slow/turbo period), single-step (debounced button) or holds it in HALTED.
module exec_sequencer #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned SLOW_MS  = 250,
  parameter int unsigned TURBO_MS = 10,
  parameter int unsigned DEB_CYC  = 500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Mode,
  input  logic       Turbo,
  input  logic       Step,
  input  logic       Halt,
  output logic       Go,
  output logic [1:0] State,
  output logic [7:0] GoCount
);

  // Periods below 2 would allow back-to-back Go, so they are raised to 2.
  localparam int unsigned SLOW_RAW  = CLK_HZ / 1000 * SLOW_MS;
  localparam int unsigned TURBO_RAW = CLK_HZ / 1000 * TURBO_MS;
  localparam int unsigned SLOW_P    = (SLOW_RAW < 2) ? 2 : SLOW_RAW;
  localparam int unsigned TURBO_P   = (TURBO_RAW < 2) ? 2 : TURBO_RAW;
  localparam int unsigned MAX_P     = (SLOW_P > TURBO_P) ? SLOW_P : TURBO_P;
  localparam int unsigned CNT_W     = $clog2(MAX_P);
  localparam int unsigned DEB_N     = (DEB_CYC < 1) ? 1 : DEB_CYC;
  localparam int unsigned DEB_W     = $clog2(DEB_N + 1);

  localparam logic [CNT_W-1:0] SLOW_TOP  = CNT_W'(SLOW_P - 1);
  localparam logic [CNT_W-1:0] TURBO_TOP = CNT_W'(TURBO_P - 1);
  localparam logic [DEB_W-1:0] DEB_TOP   = DEB_W'(DEB_N - 1);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_go;
  logic [7:0]       r_go_count;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [DEB_W-1:0] r_stab;
  logic             r_press;

  logic [CNT_W-1:0] w_top;

  // Terminal count follows Turbo every cycle so a mid-period switch takes effect at once.
  assign w_top = Turbo ? TURBO_TOP : SLOW_TOP;

  // Synchronize the button, require DEB_N stable samples, emit a pulse on the debounced rise.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_stab  <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= Step;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_deb) begin
        r_stab <= '0;
      end else if (r_stab == DEB_TOP) begin
        r_stab  <= '0;
        r_deb   <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_stab <= r_stab + DEB_W'(1);
      end
    end
  end

  // Mode FSM with period counter; Halt outranks mode change, which outranks press/timer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= ST_STEP;
      r_cnt      <= '0;
      r_go       <= 1'b0;
      r_go_count <= 8'd0;
    end else begin
      r_go <= 1'b0;
      case (r_state)
        ST_STEP: begin
          r_cnt <= '0;
          if (Halt) begin
            r_state <= ST_HALT;
          end else if (Mode) begin
            r_state <= ST_RUN;
          end else if (r_press) begin
            r_go       <= 1'b1;
            r_go_count <= r_go_count + 8'd1;
          end
        end
        ST_RUN: begin
          if (Halt) begin
            r_state <= ST_HALT;
            r_cnt   <= '0;
          end else if (!Mode) begin
            r_state <= ST_STEP;
            r_cnt   <= '0;
          end else if (r_cnt >= w_top) begin
            r_cnt      <= '0;
            r_go       <= 1'b1;
            r_go_count <= r_go_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HALT: begin
          r_cnt <= '0;
          if (r_press) begin
            r_state <= Mode ? ST_RUN : ST_STEP;
          end
        end
        default: begin
          r_state <= ST_STEP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Go      = r_go;
  assign State   = r_state;
  assign GoCount = r_go_count;

endmodule
